// File: rtl/mem_ctrl_multi.sv
// mem_ctrl_multi: arbitrates NUM_CH byte-serial read/write requests onto one
// 8-bit RAM/IO bus. Reads issue one address per cycle and capture the byte the
// cycle after. Writes stall on a full UART buffer. Reads can be aborted.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | arbitrate eligible channels, latch the winner's request
// READ     | issue addr+cnt, capture the previous byte, pulse done at end
// WRITE    | drive addr+cnt / din byte with mem_wr, stall on IO full
module mem_ctrl_multi #(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [32*NUM_CH-1:0]  ch_din,
  input  logic [3*NUM_CH-1:0]   ch_len,
  input  logic [NUM_CH-1:0]     ch_abort,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [31:0]           ch_dout
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] mask_q;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;
  logic [31:0]       cur_a;
  logic [2:0]        prev_cnt;
  logic              io_stall;
  logic              abort_g;
  logic              wr_c;

  // Anything other than 1 or 2 bytes is a full word.
  function automatic logic [2:0] len_eff(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_a    = addr_q + {29'd0, cnt_q};
  assign prev_cnt = cnt_q - 3'd1;
  assign io_stall = (cur_a[17:16] == 2'b11) && io_buffer_full;
  assign abort_g  = ch_abort[gnt_q];
  assign mem_wr   = wr_c & rdy;
  assign ch_done  = done_q;
  assign ch_dout  = (|done_q) ? data_q : 32'd0;

  // Grant search: round-robin from ptr+1, or lowest index first.
  always_comb begin
    elig  = ch_valid & ~ch_abort & ~mask_q;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 0) cand = PW'((int'(ptr_q) + 1 + i) % NUM_CH);
      else               cand = PW'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and bus drive for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    data_d   = data_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    wr_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = sel;
          ptr_d   = sel;
          addr_d  = ch_addr[32*sel +: 32];
          din_d   = ch_din[32*sel +: 32];
          len_d   = len_eff(ch_len[3*sel +: 3]);
          cnt_d   = 3'd0;
          data_d  = 32'd0;
          state_d = ch_wr[sel] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (abort_g) begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          if (cnt_q < len_q) mem_a = cur_a;
          // While frozen, keep the last issued address on the bus so the
          // byte lost during the stall is fetched again before resuming.
          if (!rdy) mem_a = (cnt_q == 3'd0) ? addr_q : addr_q + {29'd0, prev_cnt};
          if (cnt_q != 3'd0) data_d[{prev_cnt[1:0], 3'b000} +: 8] = mem_din;
          if (cnt_q < len_q) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            done_d[gnt_q] = 1'b1;
            cnt_d         = 3'd0;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        mem_a    = cur_a;
        mem_dout = din_q[{cnt_q[1:0], 3'b000} +: 8];
        wr_c     = !io_stall;
        if (!io_stall) begin
          if (cnt_q + 3'd1 == len_q) begin
            done_d[gnt_q] = 1'b1;
            cnt_d         = 3'd0;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything holds while rdy is low, done stays one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NUM_CH - 1);
      gnt_q   <= '0;
      addr_q  <= 32'd0;
      din_q   <= 32'd0;
      data_q  <= 32'd0;
      len_q   <= 3'd0;
      cnt_q   <= 3'd0;
      done_q  <= '0;
      mask_q  <= '0;
    end else begin
      done_q <= rdy ? done_d : '0;
      mask_q <= done_q;
      if (rdy) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        gnt_q   <= gnt_d;
        addr_q  <= addr_d;
        din_q   <= din_d;
        data_q  <= data_d;
        len_q   <= len_d;
        cnt_q   <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// Directed bench for mem_ctrl_multi: a round-robin and a fixed-priority
// instance share all request inputs; each has its own 1-cycle-latency RAM.
module tb_mem_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        io_full = 1'b0;
  logic [1:0]  ch_valid = '0;
  logic [1:0]  ch_wr = '0;
  logic [1:0]  ch_abort = '0;
  logic [63:0] ch_addr = '0;
  logic [63:0] ch_din = '0;
  logic [5:0]  ch_len = '0;

  logic [7:0]  rr_din = 8'd0, fp_din = 8'd0;
  logic [7:0]  rr_dout, fp_dout;
  logic [31:0] rr_a, fp_a, rr_cd, fp_cd;
  logic        rr_wr, fp_wr;
  logic [1:0]  rr_done, fp_done;

  logic [7:0]  ram [0:4095];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rr_din <= ram[rr_a[11:0]];
    fp_din <= ram[fp_a[11:0]];
  end

  mem_ctrl_multi #(.NUM_CH(2), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(rr_din), .mem_dout(rr_dout),
    .mem_a(rr_a), .mem_wr(rr_wr), .io_buffer_full(io_full),
    .ch_valid(ch_valid), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_len(ch_len), .ch_abort(ch_abort), .ch_done(rr_done), .ch_dout(rr_cd)
  );

  mem_ctrl_multi #(.NUM_CH(2), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(fp_din), .mem_dout(fp_dout),
    .mem_a(fp_a), .mem_wr(fp_wr), .io_buffer_full(io_full),
    .ch_valid(ch_valid), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_len(ch_len), .ch_abort(ch_abort), .ch_done(fp_done), .ch_dout(fp_cd)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] len);
    ch_addr[32*ch +: 32] = a;
    ch_din[32*ch +: 32]  = d;
    ch_len[3*ch +: 3]    = len;
    ch_wr[ch]            = wr;
    ch_valid[ch]         = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    checks++; if (rr_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", rr_a); end
    checks++; if (rr_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", rr_wr); end
    checks++; if (rr_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got=%h exp=0", rr_dout); end
    checks++; if (rr_done !== 2'b00 || fp_done !== 2'b00) begin errors++; $display("FAIL reset_done got=%b/%b exp=00", rr_done, fp_done); end
    checks++; if (rr_cd !== 32'd0) begin errors++; $display("FAIL reset_ch_dout got=%h exp=0", rr_cd); end
    rst = 1'b1;
  endtask

  // Both channels request 1-byte reads continuously right out of reset.
  task automatic test_contention();
    int nr = 0;
    int nf = 0;
    set_req(0, 1'b0, 32'h100, 32'd0, 3'd1);
    set_req(1, 1'b0, 32'h102, 32'd0, 3'd1);
    for (int c = 0; c < 60 && (nr < 4 || nf < 4); c++) begin
      cyc();
      if (rr_done !== 2'b00 && nr < 4) begin
        checks++;
        if (rr_done !== ((nr % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_order n=%0d got=%b exp=%b", nr, rr_done, (nr % 2 == 0) ? 2'b01 : 2'b10);
        end
        checks++;
        if (rr_cd !== ((nr % 2 == 0) ? 32'h11 : 32'h33)) begin
          errors++; $display("FAIL rr_data n=%0d got=%h", nr, rr_cd);
        end
        nr++;
      end
      if (fp_done !== 2'b00 && nf < 4) begin
        checks++;
        if (fp_done !== 2'b01) begin errors++; $display("FAIL fp_starve n=%0d got=%b exp=01", nf, fp_done); end
        checks++;
        if (fp_cd !== 32'h11) begin errors++; $display("FAIL fp_data n=%0d got=%h exp=11", nf, fp_cd); end
        nf++;
      end
    end
    checks++;
    if (nr < 4 || nf < 4) begin errors++; $display("FAIL contention_timeout rr=%0d fp=%0d exp=4", nr, nf); end
    ch_valid = '0;
    repeat (8) cyc();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 32'h100, 32'd0, 3'd4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (rr_a !== 32'h100 + k || rr_wr !== 1'b0) begin
        errors++; $display("FAIL read_addr k=%0d got=%h/%b exp=%h/0", k, rr_a, rr_wr, 32'h100 + k);
      end
    end
    cyc();
    checks++; if (rr_done !== 2'b00 || rr_a !== 32'd0) begin errors++; $display("FAIL read_t5 done=%b a=%h exp=00/0", rr_done, rr_a); end
    cyc();
    checks++; if (rr_done !== 2'b01) begin errors++; $display("FAIL read_done got=%b exp=01", rr_done); end
    checks++; if (rr_cd !== 32'h44332211) begin errors++; $display("FAIL read_data got=%h exp=44332211", rr_cd); end
    ch_valid[0] = 1'b0;
    cyc();
    checks++; if (rr_done !== 2'b00) begin errors++; $display("FAIL read_done_pulse got=%b exp=00", rr_done); end
    repeat (2) cyc();
  endtask

  task automatic test_byte_write();
    logic bad = 1'b0;
    set_req(1, 1'b1, 32'h200, 32'hAABBCCDD, 3'd2);
    cyc();
    if (rr_dout == 8'hBB || rr_dout == 8'hAA) bad = 1'b1;
    checks++;
    if (rr_a !== 32'h200 || rr_dout !== 8'hDD || rr_wr !== 1'b1) begin
      errors++; $display("FAIL write_b0 got=%h/%h/%b exp=200/dd/1", rr_a, rr_dout, rr_wr);
    end
    cyc();
    if (rr_dout == 8'hBB || rr_dout == 8'hAA) bad = 1'b1;
    checks++;
    if (rr_a !== 32'h201 || rr_dout !== 8'hCC || rr_wr !== 1'b1) begin
      errors++; $display("FAIL write_b1 got=%h/%h/%b exp=201/cc/1", rr_a, rr_dout, rr_wr);
    end
    cyc();
    checks++; if (rr_done !== 2'b10 || rr_wr !== 1'b0) begin errors++; $display("FAIL write_done got=%b/%b exp=10/0", rr_done, rr_wr); end
    ch_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (rr_dout == 8'hBB || rr_dout == 8'hAA) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL write_upper_bytes got=driven exp=never"); end
  endtask

  task automatic test_io_stall();
    set_req(0, 1'b1, 32'h30000, 32'h00000077, 3'd1);
    io_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (rr_wr !== 1'b0 || rr_done !== 2'b00) begin
        errors++; $display("FAIL io_stall k=%0d wr=%b done=%b exp=0/00", k, rr_wr, rr_done);
      end
    end
    cyc();
    io_full = 1'b0;
    #1;
    checks++;
    if (rr_wr !== 1'b1 || rr_a !== 32'h30000 || rr_dout !== 8'h77) begin
      errors++; $display("FAIL io_write got=%b/%h/%h exp=1/30000/77", rr_wr, rr_a, rr_dout);
    end
    cyc();
    checks++; if (rr_done !== 2'b01 || rr_wr !== 1'b0) begin errors++; $display("FAIL io_done got=%b/%b exp=01/0", rr_done, rr_wr); end
    ch_valid[0] = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_abort();
    set_req(0, 1'b0, 32'h100, 32'd0, 3'd4);
    cyc();
    checks++; if (rr_a !== 32'h100) begin errors++; $display("FAIL abort_a0 got=%h exp=100", rr_a); end
    cyc();
    ch_abort[0] = 1'b1;
    set_req(1, 1'b0, 32'h102, 32'd0, 3'd1);
    #1;
    checks++;
    if (rr_a !== 32'd0 || rr_wr !== 1'b0 || fp_a !== 32'd0) begin
      errors++; $display("FAIL abort_drop got=%h/%b/%h exp=0/0/0", rr_a, rr_wr, fp_a);
    end
    cyc();
    checks++; if (rr_done !== 2'b00 || rr_a !== 32'd0) begin errors++; $display("FAIL abort_idle done=%b a=%h exp=00/0", rr_done, rr_a); end
    cyc();
    ch_valid[0] = 1'b0;
    ch_abort[0] = 1'b0;
    #1;
    checks++; if (rr_a !== 32'h102) begin errors++; $display("FAIL abort_next_rr got=%h exp=102", rr_a); end
    checks++; if (fp_a !== 32'h102) begin errors++; $display("FAIL abort_next_fp got=%h exp=102", fp_a); end
    cyc();
    checks++; if (rr_done !== 2'b00) begin errors++; $display("FAIL abort_no_done got=%b exp=00", rr_done); end
    cyc();
    checks++; if (rr_done !== 2'b10 || rr_cd !== 32'h33) begin errors++; $display("FAIL abort_ch1_done got=%b/%h exp=10/33", rr_done, rr_cd); end
    ch_valid[1] = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_freeze();
    int t = 2;
    int got = -1;
    set_req(0, 1'b0, 32'h100, 32'd0, 3'd4);
    cyc();
    cyc();
    checks++; if (rr_a !== 32'h101) begin errors++; $display("FAIL freeze_a1 got=%h exp=101", rr_a); end
    cyc();
    rdy = 1'b0;
    #1;
    checks++; if (rr_wr !== 1'b0 || rr_a !== 32'h101) begin errors++; $display("FAIL freeze_hold got=%b/%h exp=0/101", rr_wr, rr_a); end
    cyc();
    cyc();
    rdy = 1'b1;
    t = 5;
    #1;
    checks++; if (rr_a !== 32'h102) begin errors++; $display("FAIL freeze_resume got=%h exp=102", rr_a); end
    for (int c = 0; c < 20; c++) begin
      cyc();
      t++;
      if (rr_done !== 2'b00) begin
        got = t;
        break;
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL freeze_latency got=%0d exp=8", got); end
    checks++; if (rr_done !== 2'b01 || rr_cd !== 32'h44332211) begin errors++; $display("FAIL freeze_data got=%b/%h exp=01/44332211", rr_done, rr_cd); end
    ch_valid[0] = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid_write();
    set_req(1, 1'b1, 32'h200, 32'hAABBCCDD, 3'd2);
    cyc();
    checks++; if (rr_wr !== 1'b1) begin errors++; $display("FAIL rstw_pre got=%b exp=1", rr_wr); end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (rr_wr !== 1'b0 || rr_a !== 32'd0 || fp_wr !== 1'b0) begin
      errors++; $display("FAIL rstw_async got=%b/%h/%b exp=0/0/0", rr_wr, rr_a, fp_wr);
    end
    ch_valid = '0;
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (rr_a !== 32'd0 || rr_done !== 2'b00) begin errors++; $display("FAIL rstw_idle got=%h/%b exp=0/00", rr_a, rr_done); end
    set_req(0, 1'b0, 32'h100, 32'd0, 3'd1);
    set_req(1, 1'b0, 32'h102, 32'd0, 3'd1);
    cyc();
    checks++; if (rr_a !== 32'h100) begin errors++; $display("FAIL rstw_ptr got=%h exp=100", rr_a); end
    cyc();
    cyc();
    checks++; if (rr_done !== 2'b01 || rr_cd !== 32'h11) begin errors++; $display("FAIL rstw_read got=%b/%h exp=01/11", rr_done, rr_cd); end
    ch_valid = '0;
    repeat (4) cyc();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
    ram[12'h100] = 8'h11;
    ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44;
    test_reset();
    test_contention();
    test_single_read();
    test_byte_write();
    test_io_stall();
    test_abort();
    test_freeze();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
